abs_bipolar_multi: RTL and testbench

- Multi-channel bipolar stochastic-bitstream absolute-value / rectifier unit for the unary compute kernels.
- Each channel tracks its input stream's running sign with a saturating up/down counter. The sign decision can have hysteresis.
- Each channel emits an output bitstream selected by mode: |x|, ReLU(x), x or -x.
- Sits between bipolar arithmetic kernels (mul/add) and downstream activation or accumulation stages.

---
 rtl/abs_bipolar_multi.sv | 89 ++++++++
 tb/tb_abs_bipolar_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/abs_bipolar_multi.sv
`timescale 1ns/1ps
// Multi-channel bipolar stochastic-stream rectifier: each channel tracks its stream sign with a
// saturating up/down counter (optional hysteresis) and emits |x|, ReLU(x), x or -x.
module abs_bipolar_multi #(
    parameter int NCH  = 4,
    parameter int DEP  = 3,
    parameter int HYST = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           clr,
    input  logic [1:0]     mode,
    input  logic [NCH-1:0] value,
    output logic [NCH-1:0] sign,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] sat_hi,
    output logic [NCH-1:0] sat_lo
);
    localparam int MID = 2 ** (DEP - 1);
    localparam int MAX = 2 ** DEP - 1;
    localparam logic [DEP-1:0] MID_V = DEP'(MID);
    localparam logic [DEP-1:0] MAX_V = DEP'(MAX);
    // Both thresholds stay within [1, MAX] for any legal HYST, so DEP bits suffice.
    localparam logic [DEP-1:0] POS_TH = DEP'(MID + HYST);
    localparam logic [DEP-1:0] NEG_TH = DEP'(MID - HYST);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DEP-1:0] cnt_reg, cnt_next;
            logic           sgn_reg, sgn_next;
            logic           tog_reg, tog_next;
            logic           out_bit;

            always_comb begin
                cnt_next = cnt_reg;
                sgn_next = sgn_reg;
                tog_next = tog_reg;
                if (clr) begin
                    cnt_next = MID_V;
                    sgn_next = 1'b0;
                    tog_next = 1'b0;
                end else if (en) begin
                    if (value[gi] && cnt_reg != MAX_V)
                        cnt_next = cnt_reg + 1'b1;
                    else if (!value[gi] && cnt_reg != '0)
                        cnt_next = cnt_reg - 1'b1;
                    // Sign is decided from the post-edge count so it never lags cnt.
                    if (cnt_next >= POS_TH)
                        sgn_next = 1'b0;
                    else if (cnt_next < NEG_TH)
                        sgn_next = 1'b1;
                    tog_next = ~tog_reg;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= MID_V;
                    sgn_reg <= 1'b0;
                    tog_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    sgn_reg <= sgn_next;
                    tog_reg <= tog_next;
                end
            end

            // tog_reg is an alternating stream, i.e. a bipolar zero for the ReLU negative branch.
            always_comb begin
                out_bit = 1'b0;
                if (en) begin
                    case (mode)
                        2'b00:   out_bit = value[gi] ^ sgn_reg;
                        2'b01:   out_bit = sgn_reg ? tog_reg : value[gi];
                        2'b10:   out_bit = value[gi];
                        default: out_bit = ~value[gi];
                    endcase
                end
            end

            assign sign[gi]   = sgn_reg;
            assign out[gi]    = out_bit;
            assign sat_hi[gi] = (cnt_reg == MAX_V);
            assign sat_lo[gi] = (cnt_reg == '0);
        end
    endgenerate
endmodule

// File: tb/tb_abs_bipolar_multi.sv
`timescale 1ns/1ps
// Directed scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor
// pops and compares them against a HYST=0 instance (dut 0) and a HYST=1 instance (dut 1).
module tb_abs_bipolar_multi;
    logic       clk = 1'b0;
    logic       rst_n, en, clr;
    logic [1:0] mode;
    logic [3:0] value;
    logic [3:0] sign_a, out_a, hi_a, lo_a;
    logic [3:0] sign_b, out_b, hi_b, lo_b;

    always #5 clk = ~clk;

    abs_bipolar_multi #(.NCH(4), .DEP(3), .HYST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .value(value),
        .sign(sign_a), .out(out_a), .sat_hi(hi_a), .sat_lo(lo_a));

    abs_bipolar_multi #(.NCH(4), .DEP(3), .HYST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .value(value),
        .sign(sign_b), .out(out_b), .sat_hi(hi_b), .sat_lo(lo_b));

    typedef struct {
        string      name;
        int         dut;
        logic [3:0] mask;
        logic [3:0] sgn;
        logic [3:0] o;
        logic [3:0] hi;
        logic [3:0] lo;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int d, input logic [3:0] m,
                       input logic [3:0] s, input logic [3:0] o,
                       input logic [3:0] h, input logic [3:0] l);
        exp_t e;
        e.name = nm; e.dut = d; e.mask = m; e.sgn = s; e.o = o; e.hi = h; e.lo = l;
        q.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [3:0] act,
                       input logic [3:0] exp, input logic [3:0] m);
        checks++;
        if ((act & m) !== (exp & m)) begin
            errors++;
            $display("FAIL %s.%s got %b expected %b (mask %b) at %0t", nm, fld, act, exp, m, $time);
        end
    endtask

    // Monitor: every queued expectation refers to the cycle in which the monitor sees it.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.dut == 0) begin
                cmp(e.name, "sign", sign_a, e.sgn, e.mask);
                cmp(e.name, "out", out_a, e.o, e.mask);
                cmp(e.name, "sat_hi", hi_a, e.hi, e.mask);
                cmp(e.name, "sat_lo", lo_a, e.lo, e.mask);
            end else begin
                cmp(e.name, "sign", sign_b, e.sgn, e.mask);
                cmp(e.name, "out", out_b, e.o, e.mask);
                cmp(e.name, "sat_hi", hi_b, e.hi, e.mask);
                cmp(e.name, "sat_lo", lo_b, e.lo, e.mask);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic [1:0] m, input logic [3:0] v);
        en = e; clr = c; mode = m; value = v;
    endtask

    task automatic do_clr();
        drive(1'b0, 1'b1, 2'b10, 4'b0000);
        tick();
        clr = 1'b0;
    endtask

    logic [4:0] hyst_seq;
    logic [4:0] hyst_sign_b;
    logic [4:0] hyst_sign_a;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset", 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("reset_b", 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        tick();

        // Saturation on ch0: up to MAX, then down to 0.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 2'b10, 4'hF);
            chk($sformatf("sat_up%0d", i), 0, 4'b0001, 4'h0, 4'hF, (i >= 3) ? 4'hF : 4'h0, 4'h0);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 2'b10, 4'h0);
            chk($sformatf("sat_dn%0d", k), 0, 4'b0001, (k >= 4) ? 4'hF : 4'h0, 4'h0,
                (k == 0) ? 4'hF : 4'h0, (k == 7) ? 4'hF : 4'h0);
            tick();
        end
        drive(1'b0, 1'b0, 2'b10, 4'h0);
        chk("sat_hold", 0, 4'b0001, 4'hF, 4'h0, 4'h0, 4'hF);
        tick();

        // Clear with en low; the clear cycle still shows pre-clear state.
        drive(1'b0, 1'b1, 2'b10, 4'h0);
        chk("clr_cycle", 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF);
        tick();
        drive(1'b0, 1'b0, 2'b10, 4'h0);
        chk("clr_after", 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("clr_after_b", 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        tick();

        // Abs on ch1 with a -1 stream.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 2'b00, 4'h0);
            chk($sformatf("abs%0d", k), 0, 4'b0010, (k > 0) ? 4'hF : 4'h0,
                (k > 0) ? 4'hF : 4'h0, 4'h0, 4'h0);
            tick();
        end

        // Hysteresis: counts 4,3,2,3,4 before each edge, 5 afterwards.
        do_clr();
        hyst_seq    = 5'b11100;
        hyst_sign_b = 5'b11100;
        hyst_sign_a = 5'b01110;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 2'b10, {4{hyst_seq[k]}});
            chk($sformatf("hyst_b%0d", k), 1, 4'b0001, {4{hyst_sign_b[k]}}, {4{hyst_seq[k]}}, 4'h0, 4'h0);
            chk($sformatf("hyst_a%0d", k), 0, 4'b0001, {4{hyst_sign_a[k]}}, {4{hyst_seq[k]}}, 4'h0, 4'h0);
            tick();
        end
        drive(1'b0, 1'b0, 2'b10, 4'h0);
        chk("hyst_b_end", 1, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("hyst_a_end", 0, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0);
        tick();

        // ReLU on ch2 driven negative, with an en-low freeze in the middle.
        do_clr();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 2'b01, 4'h0);
            chk($sformatf("relu%0d", k), 0, 4'b0100, (k > 0) ? 4'hF : 4'h0,
                (k == 1) ? 4'hF : 4'h0, 4'h0, 4'h0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 2'b01, 4'h0);
            chk($sformatf("relu_frz%0d", k), 0, 4'b0100, 4'hF, 4'h0, 4'h0, 4'h0);
            tick();
        end
        for (int k = 3; k < 6; k++) begin
            drive(1'b1, 1'b0, 2'b01, 4'h0);
            chk($sformatf("relu%0d", k), 0, 4'b0100, 4'hF, (k != 4) ? 4'hF : 4'h0,
                4'h0, (k >= 4) ? 4'hF : 4'h0);
            tick();
        end

        // Clear while ch3 is at MAX and ch0 at 0.
        do_clr();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 2'b10, 4'b1000);
            tick();
        end
        drive(1'b0, 1'b0, 2'b10, 4'b1000);
        chk("pre_clr", 0, 4'b1001, 4'b0001, 4'h0, 4'b1000, 4'b0001);
        tick();
        drive(1'b1, 1'b1, 2'b10, 4'b1010);
        chk("clr_bypass", 0, 4'hF, 4'b0111, 4'b1010, 4'b1000, 4'b0111);
        tick();
        drive(1'b1, 1'b0, 2'b11, 4'b1010);
        chk("negate", 0, 4'hF, 4'h0, 4'b0101, 4'h0, 4'h0);
        tick();
        // ch0/ch2 went to 3 (negative); tog is 1 after one edge from a cleared 0.
        drive(1'b1, 1'b0, 2'b01, 4'h0);
        chk("relu_tog", 0, 4'hF, 4'b0101, 4'b0101, 4'h0, 4'h0);
        tick();
        repeat (4) begin
            drive(1'b1, 1'b0, 2'b01, 4'h0);
            tick();
        end
        drive(1'b0, 1'b0, 2'b01, 4'h0);
        chk("pre_rst", 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF);
        tick();

        // Asynchronous reset: state must drop before any further clock edge.
        rst_n = 1'b0;
        chk("async_rst", 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("async_rst_b", 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int w = 0; w < 10 && q.size() > 0; w++) tick();
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
